line_raster_gen: RTL

- Bresenham line rasterizer feeding the pixel stream (X, Y, RGBA) consumed by the framebuffer-write / fill stage.
- Sits directly upstream of the pixel sink in the line-and-triangle path; the triangle setup logic issues it one edge at a time.
- Emits exactly one pixel per accepted handshake, endpoints inclusive.

---
 rtl/line_raster_gen.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/line_raster_gen.sv
`default_nettype none
// ============================================================================
// Module   : line_raster_gen
// Brief    : Bresenham line rasterizer emitting one (X, Y, RGBA) pixel per
//            accepted valid/ready handshake, endpoints inclusive.
// Revision : 1.0 - initial release
// ============================================================================
module line_raster_gen #(
    parameter int XW = 10,
    parameter int YW = 9,
    parameter int CW = 12,
    parameter int EW = 13
) (
    input  logic          clk,
    input  logic          Mreset_n,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] color,
    output logic [XW-1:0] px,
    output logic [YW-1:0] py,
    output logic [CW-1:0] pcolor,
    output logic          pvalid,
    input  logic          pready,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_EMIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic signed [EW-1:0] c_zero = '0;

    state_t                r_state;
    logic [XW-1:0]         r_x0;
    logic [XW-1:0]         r_x1;
    logic [YW-1:0]         r_y0;
    logic [YW-1:0]         r_y1;
    logic signed [EW-1:0]  r_dx;
    logic signed [EW-1:0]  r_dy;
    logic signed [EW-1:0]  r_err;
    logic                  r_sx;
    logic                  r_sy;

    logic [XW-1:0]         w_adx;
    logic [YW-1:0]         w_ady;
    logic signed [EW-1:0]  w_dx;
    logic signed [EW-1:0]  w_dy;
    logic signed [EW-1:0]  w_e2;
    logic                  w_step_x;
    logic                  w_step_y;
    logic signed [EW-1:0]  w_err_next;
    logic                  w_last;

    // Magnitudes are taken on the unsigned coordinates, then zero-extended
    // so the signed error arithmetic never sees a wrapped value.
    assign w_adx = (r_x1 >= r_x0) ? (r_x1 - r_x0) : (r_x0 - r_x1);
    assign w_ady = (r_y1 >= r_y0) ? (r_y1 - r_y0) : (r_y0 - r_y1);
    assign w_dx  = {{(EW-XW){1'b0}}, w_adx};
    assign w_dy  = c_zero - {{(EW-YW){1'b0}}, w_ady};

    // Both axis steps are decided from the same pre-update error term.
    assign w_e2       = {r_err[EW-2:0], 1'b0};
    assign w_step_x   = (w_e2 >= r_dy);
    assign w_step_y   = (w_e2 <= r_dx);
    assign w_err_next = r_err + (w_step_x ? r_dy : c_zero) + (w_step_y ? r_dx : c_zero);
    assign w_last     = (px == r_x1) && (py == r_y1);

    always_ff @(posedge clk or negedge Mreset_n) begin
        if (!Mreset_n) begin
            r_state <= S_IDLE;
            r_x0    <= '0;
            r_x1    <= '0;
            r_y0    <= '0;
            r_y1    <= '0;
            r_dx    <= '0;
            r_dy    <= '0;
            r_err   <= '0;
            r_sx    <= 1'b0;
            r_sy    <= 1'b0;
            px      <= '0;
            py      <= '0;
            pcolor  <= '0;
            pvalid  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0    <= x0;
                        r_y0    <= y0;
                        r_x1    <= x1;
                        r_y1    <= y1;
                        pcolor  <= color;
                        busy    <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_dx    <= w_dx;
                    r_dy    <= w_dy;
                    r_err   <= w_dx + w_dy;
                    r_sx    <= (r_x0 < r_x1);
                    r_sy    <= (r_y0 < r_y1);
                    px      <= r_x0;
                    py      <= r_y0;
                    pvalid  <= 1'b1;
                    r_state <= S_EMIT;
                end
                S_EMIT: begin
                    if (pready) begin
                        if (w_last) begin
                            pvalid  <= 1'b0;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err <= w_err_next;
                            if (w_step_x) begin
                                px <= r_sx ? (px + 1'b1) : (px - 1'b1);
                            end
                            if (w_step_y) begin
                                py <= r_sy ? (py + 1'b1) : (py - 1'b1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
